// File: rtl/exp_fx.sv
// Fixed-point e^x / 2^x unit: range reduction to 2^q * 2^f, then a Horner series for 2^f.
// One request at a time; the latency is fixed at 3 + 2*TERMS cycles.
module exp_fx #(
  parameter int IW    = 16,
  parameter int IF    = 8,
  parameter int OW    = 24,
  parameter int OF    = 8,
  parameter int TERMS = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_start,
  input  logic [IW-1:0] i_val,
  input  logic          i_base2,
  output logic          o_busy,
  output logic          o_done,
  output logic [OW-1:0] o_exp,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int XW = IW + 16;   // operand rescaled to Q.16
  localparam int PW = XW + 18;   // x * LOG2E without wrap
  localparam int TW = XW + 2;    // t = (x * LOG2E) >>> 16
  localparam int QW = TW - 16;   // integer part q
  localparam int AW = 18;        // accumulator, holds values below 2.0 in Q.16
  localparam int RW = AW + OW;   // scaled result before the saturation check

  localparam logic signed [17:0] LOG2E = 18'sd94548;
  localparam logic [15:0]        LN2   = 16'd45426;
  localparam logic [3:0]         KINIT = 4'(TERMS);

  typedef enum logic [2:0] {StIdle, StReduce, StFrac, StHmul, StHadd, StScale} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          val_q, val_d;
  logic                   base2_q, base2_d;
  logic signed [QW-1:0]   q_q, q_d;
  logic [15:0]            f_q, f_d, u_q, u_d;
  logic [AW-1:0]          acc_q, acc_d, m_q, m_d;
  logic [3:0]             k_q, k_d;
  logic [OW-1:0]          exp_q, exp_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;

  logic signed [XW-1:0]   x;
  logic signed [PW-1:0]   xe, le;
  logic signed [TW-1:0]   t;
  logic [RW-1:0]          r;
  int                     sh;

  // round(65536 / k)
  function automatic logic [16:0] recip(input logic [3:0] k);
    case (k)
      4'd1:    recip = 17'd65536;
      4'd2:    recip = 17'd32768;
      4'd3:    recip = 17'd21845;
      4'd4:    recip = 17'd16384;
      4'd5:    recip = 17'd13107;
      4'd6:    recip = 17'd10923;
      4'd7:    recip = 17'd9362;
      4'd8:    recip = 17'd8192;
      4'd9:    recip = 17'd7282;
      4'd10:   recip = 17'd6554;
      default: recip = 17'd0;
    endcase
  endfunction

  assign x  = XW'($signed(val_q)) <<< (16 - IF);
  assign xe = PW'(x);
  assign le = PW'(LOG2E);
  assign t  = base2_q ? TW'(x) : TW'((xe * le) >>> 16);

  // Left by q then right by 16-OF folds into one shift of q-(16-OF); floor is preserved.
  always_comb begin
    sh = int'(q_q) - (16 - OF);
    r  = '0;
    if (sh >= 0) begin
      r = RW'(acc_q) << sh;
    end else if (sh > -AW) begin
      r = RW'(acc_q) >> (-sh);
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    base2_d = base2_q;
    q_d     = q_q;
    f_d     = f_q;
    u_d     = u_q;
    acc_d   = acc_q;
    m_d     = m_q;
    k_d     = k_q;
    exp_d   = exp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          val_d   = i_val;
          base2_d = i_base2;
          state_d = StReduce;
        end
      end
      StReduce: begin
        q_d     = t[TW-1:16];
        f_d     = t[15:0];
        state_d = StFrac;
      end
      StFrac: begin
        u_d     = 16'((32'(f_q) * 32'(LN2)) >> 16);
        acc_d   = 18'd65536;
        k_d     = KINIT;
        state_d = StHmul;
      end
      StHmul: begin
        m_d     = AW'((34'(acc_q) * 34'(u_q)) >> 16);
        state_d = StHadd;
      end
      StHadd: begin
        acc_d   = 18'd65536 + AW'((35'(m_q) * 35'(recip(k_q))) >> 16);
        k_d     = k_q - 4'd1;
        state_d = (k_q == 4'd1) ? StScale : StHmul;
      end
      StScale: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (int'(q_q) >= OW - OF || r[RW-1:OW] != '0) begin
          exp_d = '1;
          ovf_d = 1'b1;
          unf_d = 1'b0;
        end else if (r == '0) begin
          exp_d = '0;
          ovf_d = 1'b0;
          unf_d = 1'b1;
        end else begin
          exp_d = r[OW-1:0];
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      val_q   <= '0;
      base2_q <= 1'b0;
      q_q     <= '0;
      f_q     <= '0;
      u_q     <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      k_q     <= '0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      base2_q <= base2_d;
      q_q     <= q_d;
      f_q     <= f_d;
      u_q     <= u_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (state_q != StIdle);
  assign o_done = done_q;
  assign o_exp  = exp_q;
  assign o_ovf  = ovf_q;
  assign o_unf  = unf_q;

endmodule

// File: tb/tb_exp_fx.sv
// Bench for exp_fx at default parameters: directed spec points, protocol checks and
// random operands compared against an arithmetic model of the algorithm.
module tb_exp_fx;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_val = '0;
  logic        i_base2 = 1'b0;
  logic        o_busy, o_done, o_ovf, o_unf;
  logic [23:0] o_exp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  exp_fx dut (
    .CLK     (CLK),
    .RST     (RST),
    .i_start (i_start),
    .i_val   (i_val),
    .i_base2 (i_base2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_exp   (o_exp),
    .o_ovf   (o_ovf),
    .o_unf   (o_unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec algorithm in plain 64-bit integer arithmetic.
  function automatic void model(input logic [15:0] v, input logic b2,
                                output logic [23:0] e, output logic ov, output logic un);
    longint x, t, q, f, u, acc, m, r, rc;
    x = longint'($signed(v)) * 256;
    t = b2 ? x : ((x * 94548) >>> 16);
    q = t >>> 16;
    f = t - q * 65536;
    u = (f * 45426) >>> 16;
    acc = 65536;
    for (int k = 6; k >= 1; k--) begin
      rc  = (65536 + k / 2) / k;
      m   = (acc * u) >>> 16;
      acc = 65536 + ((m * rc) >>> 16);
    end
    ov = 1'b0;
    un = 1'b0;
    e  = '0;
    if (q >= 16) begin
      ov = 1'b1;
      e  = '1;
    end else begin
      if (q >= 0) r = acc << q;
      else if (q > -60) r = acc >> (-q);
      else r = 0;
      r = r >> 8;
      if (r >= 64'd16777216) begin
        ov = 1'b1;
        e  = '1;
      end else if (r == 0) begin
        un = 1'b1;
      end else begin
        e = r[23:0];
      end
    end
  endfunction

  task automatic start(input logic [15:0] v, input logic b2);
    @(negedge CLK);
    i_start = 1'b1;
    i_val   = v;
    i_base2 = b2;
    @(posedge CLK);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic req(input logic [15:0] v, input logic b2, input string tag, input bit hold);
    logic [23:0] e;
    logic ov, un;
    int n;
    model(v, b2, e, ov, un);
    start(v, b2);
    chk({tag, " busy"}, o_busy, 1);
    wait_done(n);
    chk({tag, " latency"}, n, 15);
    chk({tag, " exp"}, o_exp, e);
    chk({tag, " ovf"}, o_ovf, ov);
    chk({tag, " unf"}, o_unf, un);
    chk({tag, " busy_fall"}, o_busy, 0);
    if (hold) begin
      @(posedge CLK);
      #1;
      chk({tag, " done_pulse"}, o_done, 0);
      chk({tag, " exp_hold"}, o_exp, e);
    end
  endtask

  task automatic near(input string tag, input int exp);
    int d;
    d = int'(o_exp) - exp;
    chk(tag, (d >= -1 && d <= 1), 1);
  endtask

  initial begin
    logic [23:0] e;
    logic ov, un;
    int ndone;
    logic [23:0] got;

    #1;
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk("rst exp", o_exp, 0);
    chk("rst ovf", o_ovf, 0);
    chk("rst unf", o_unf, 0);
    #20;
    @(negedge CLK);
    RST = 1'b0;

    req(16'h0000, 1'b0, "zero_e", 1);
    chk("zero_e one", o_exp, 24'h000100);
    req(16'h0000, 1'b1, "zero_2", 1);
    chk("zero_2 one", o_exp, 24'h000100);
    req(16'h0100, 1'b0, "e_pos1", 1);
    near("e_pos1 tol", 'h2B8);
    req(16'hFF00, 1'b0, "e_neg1", 1);
    near("e_neg1 tol", 'h5E);
    req(16'h0300, 1'b1, "p2_3", 1);
    chk("p2_3 exact", o_exp, 24'h000800);
    req(16'hFF80, 1'b1, "p2_mhalf", 1);
    near("p2_mhalf tol", 'hB5);
    req(16'h1400, 1'b0, "e_20", 1);
    chk("e_20 sat", {o_ovf, o_exp}, {1'b1, 24'hFFFFFF});
    req(16'hF600, 1'b0, "e_m10", 1);
    chk("e_m10 flush", {o_unf, o_exp}, {1'b1, 24'h000000});
    for (int i = -3; i <= 6; i++) begin
      req(16'(i * 256), 1'b1, "p2_int", 0);
      chk("p2_int pow", o_exp, 24'(1 << (i + 8)));
    end

    // Second request issued while o_done of the first is high.
    req(16'h0080, 1'b0, "b2b_a", 0);
    req(16'h0200, 1'b1, "b2b_b", 1);

    // A start pulse while busy must be ignored.
    model(16'h0140, 1'b0, e, ov, un);
    start(16'h0140, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    i_start = 1'b1;
    i_val   = 16'h7000;
    i_base2 = 1'b1;
    @(negedge CLK);
    i_start = 1'b0;
    ndone = 0;
    got   = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #1;
      if (o_done === 1'b1) begin
        ndone++;
        got = o_exp;
      end
    end
    chk("busy_ign count", ndone, 1);
    chk("busy_ign exp", got, e);

    // Reset in the middle of a computation.
    start(16'h0200, 1'b0);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort busy", o_busy, 0);
    chk("abort done", o_done, 0);
    chk("abort exp", o_exp, 0);
    chk("abort ovf", o_ovf, 0);
    chk("abort unf", o_unf, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge CLK);
      #1;
      if (o_done === 1'b1) ndone++;
    end
    chk("abort no_done", ndone, 0);
    req(16'h0100, 1'b0, "post_rst", 1);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] v;
      logic b2;
      if (i % 2 == 0) v = 16'($urandom);
      else v = 16'($urandom_range(0, 4095)) - 16'd2048;
      b2 = 1'($urandom);
      req(v, b2, "rand", bit'(i % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exp_fx.md
EXP_FX -- requirements
Module: exp_fx

Interface
REQ-001 SHALL have parameter IW, default 16, signed input width.
REQ-002 SHALL have parameter IF, default 8, input fraction bits; legal range 0..16.
REQ-003 SHALL have parameter OW, default 24, unsigned output width.
REQ-004 SHALL have parameter OF, default 8, output fraction bits; legal range 0..16, OF < OW.
REQ-005 SHALL have parameter TERMS, default 6, Horner polynomial order; legal range 2..10.
REQ-006 SHALL have port CLK, input, 1, clock; all state changes on the rising edge.
REQ-007 SHALL have port RST, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port i_start, input, 1, request strobe.
REQ-009 SHALL have port i_val, input, IW, signed operand in Q(IW-IF).IF.
REQ-010 SHALL have port i_base2, input, 1, 1 = compute 2^x, 0 = compute e^x.
REQ-011 SHALL have port o_busy, output, 1, computation in progress.
REQ-012 SHALL have port o_done, output, 1, one-cycle result-valid pulse.
REQ-013 SHALL have port o_exp, output, OW, result in unsigned Q(OW-OF).OF.
REQ-014 SHALL have port o_ovf, output, 1, result saturated high.
REQ-015 SHALL have port o_unf, output, 1, result flushed to zero.

Function
REQ-016 SHALL accept a request on an edge with i_start=1 and o_busy=0, capturing i_val and i_base2; i_start while busy SHALL be ignored.
REQ-017 SHALL use internal working precision WF=16 with constants LOG2E=94548 and LN2=45426 in Q.16, plus a table RECIP[k]=round(65536/k), k=1..TERMS.
REQ-018 SHALL use FSM states IDLE -> REDUCE -> FRAC -> HMUL <-> HADD (TERMS passes) -> SCALE -> IDLE.
REQ-019 REDUCE SHALL form x = i_val << (16-IF); t = (x*LOG2E)>>>16 if i_base2=0, else t = x; this state takes one cycle in both modes.
REQ-020 REDUCE SHALL split t into q = t>>>16 (floor) and f = t - (q<<16), with f in [0,1).
REQ-021 FRAC SHALL compute u = (f*LN2)>>16, initialise acc = 65536 and k = TERMS.
REQ-022 HMUL SHALL compute m = (acc*u)>>16; HADD SHALL compute acc = 65536 + ((m*RECIP[k])>>16), then decrement k; it SHALL exit to SCALE after k=1.
REQ-023 All right shifts SHALL truncate toward minus infinity; intermediate products SHALL be wide enough never to wrap.
REQ-024 SCALE SHALL compute r = acc shifted left by q (right by -q if q<0), then shifted right by 16-OF.
REQ-025 If q >= OW-OF or r >= 2^OW, SCALE SHALL output o_exp = all ones and o_ovf=1.
REQ-026 Otherwise, if r = 0, SCALE SHALL output o_exp = 0 and o_unf=1; otherwise o_exp = r and both flags 0.
REQ-027 Latency SHALL be fixed: o_done=1 exactly 3+2*TERMS cycles after the accepting edge (15 cycles at defaults), independent of mode and value.
REQ-028 o_busy SHALL rise on the accepting edge and fall on the edge that raises o_done.
REQ-029 A new request MAY be accepted on the cycle o_done is high.
REQ-030 o_done SHALL be high for one cycle only.
REQ-031 o_exp, o_ovf and o_unf SHALL update only with o_done and hold until the next o_done.
REQ-032 i_val = 0 SHALL yield exactly 1.0 (acc remains 65536) in both modes.
REQ-033 In base-2 mode, integer inputs SHALL yield exact powers of two.

Reset
REQ-034 RST=1 SHALL force state IDLE, o_busy=0, o_done=0, o_exp=0, o_ovf=0 and o_unf=0 immediately, regardless of CLK.
REQ-035 RST asserted mid-computation SHALL abort without asserting o_done; the first request after release SHALL behave as from power-up.

Verification
REQ-036 At defaults, i_val=0x0000, i_base2=0 -> after 15 cycles o_done=1, o_exp=0x000100, flags 0.
REQ-037 i_val=0x0100 (1.0), base e -> o_exp=0x0002B8 +/-1 (e*256); i_val=0xFF00 (-1.0) -> o_exp=0x00005E +/-1.
REQ-038 i_val=0x0300, i_base2=1 -> o_exp=0x000800 exact; i_val=0xFF80 (-0.5), base 2 -> 0x0000B5 +/-1.
REQ-039 i_val=0x1400 (20.0), base e -> o_exp=0xFFFFFF, o_ovf=1; i_val=0xF600 (-10.0) -> o_exp=0, o_unf=1.
REQ-040 Pulse i_start during busy -> ignored, single o_done; assert RST at cycle 7 -> outputs zero at once, no o_done; the next request returns the correct result.
